// File: rtl/led_row_scanner.sv
// led_row_scanner: frame-latched, blanked row scan driving a 3-to-8 decoder and column lines.
module led_row_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 frame_valid,
  input  logic [ROWS*COLS-1:0] frame_data,
  output logic                 frame_ack,
  output logic [2:0]           row_sel,
  output logic                 row_ena,
  output logic [COLS-1:0]      cols,
  output logic                 frame_done,
  output logic                 busy
);
  localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
  state_t state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ROWS*COLS-1:0] buf_q, buf_d;
  logic frame_ack_q, frame_ack_d, row_ena_q, row_ena_d, frame_done_q, frame_done_d, busy_q, busy_d;
  logic [2:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] cols_q, cols_d;
  logic cap, expire, last_row;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    cnt_d = cnt_q;
    cap = 1'b0;
    expire = cnt_q == '0;
    last_row = row_q == 3'(ROWS - 1);
    case (state_q)
      IDLE: if (ena && frame_valid) begin
        cap = 1'b1;
        row_d = '0;
        state_d = BLANK;
        cnt_d = CW'(BLANK_CYCLES - 1);
      end
      BLANK: if (expire) begin
        state_d = DRIVE;
        cnt_d = CW'(DWELL_CYCLES - 1);
      end else cnt_d = cnt_q - 1'b1;
      DRIVE: if (!expire) cnt_d = cnt_q - 1'b1;
      else if (!last_row) begin
        row_d = row_q + 3'd1;
        state_d = BLANK;
        cnt_d = CW'(BLANK_CYCLES - 1);
      end else begin
        // ena and frame_valid are only honoured here so a frame never tears mid-scan
        row_d = '0;
        state_d = ena ? BLANK : IDLE;
        cnt_d = ena ? CW'(BLANK_CYCLES - 1) : '0;
        cap = ena && frame_valid;
      end
      default: state_d = IDLE;
    endcase
    buf_d = cap ? frame_data : buf_q;
    // outputs are precomputed from next-state values so they register with the state
    frame_ack_d = cap;
    row_sel_d = row_d;
    row_ena_d = state_d == DRIVE;
    cols_d = state_d == DRIVE ? buf_d[int'(row_d)*COLS +: COLS] : '0;
    frame_done_d = state_d == DRIVE && row_d == 3'(ROWS - 1) && cnt_d == '0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
      frame_ack_q <= 1'b0;
      row_sel_q <= '0;
      row_ena_q <= 1'b0;
      cols_q <= '0;
      frame_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      frame_ack_q <= frame_ack_d;
      row_sel_q <= row_sel_d;
      row_ena_q <= row_ena_d;
      cols_q <= cols_d;
      frame_done_q <= frame_done_d;
      busy_q <= busy_d;
    end
  end
  assign frame_ack = frame_ack_q;
  assign row_sel = row_sel_q;
  assign row_ena = row_ena_q;
  assign cols = cols_q;
  assign frame_done = frame_done_q;
  assign busy = busy_q;
endmodule
